// File: rtl/c8_bank_loader.sv
// Beat-serial writer for the c8 select/priority stage: scatters (bank, lane, bit) beats into two shadow banks, commits atomically on the last beat.
// Optional C8_LOADER_PARITY_EN adds in_par and a parity error bit in out_err[2].
module c8_bank_loader #(
  parameter int LANES     = 8,
  parameter int LANE_W    = 3,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bank,
  input  logic [LANE_W-1:0]    in_lane,
  input  logic                 in_data,
  input  logic                 in_mode,
  input  logic                 in_last,
`ifdef C8_LOADER_PARITY_EN
  input  logic                 in_par,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_bank_a,
  output logic [LANES-1:0]     out_bank_b,
  output logic                 out_mode,
  output logic [2*LANES-1:0]   out_wmask,
`ifdef C8_LOADER_PARITY_EN
  output logic [2:0]           out_err
`else
  output logic [1:0]           out_err
`endif
);

`ifdef C8_LOADER_PARITY_EN
  localparam int ERR_W = 3;
`else
  localparam int ERR_W = 2;
`endif
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [LANE_W:0] LANES_C = (LANE_W + 1)'(LANES);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [LANES-1:0]   shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d;
  logic [LANES-1:0]   wm_a_q, wm_a_d, wm_b_q, wm_b_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANES-1:0]   com_a_q, com_a_d, com_b_q, com_b_d;
  logic [LANES-1:0]   com_wm_a_q, com_wm_a_d, com_wm_b_q, com_wm_b_d;
  logic [ERR_W-1:0]   com_err_q, com_err_d;
  logic               com_mode_q, com_mode_d;

  logic accept, commit, lane_ok, ovf, par_ok, do_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      wm_a_q     <= '0;
      wm_b_q     <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      com_a_q    <= '0;
      com_b_q    <= '0;
      com_wm_a_q <= '0;
      com_wm_b_q <= '0;
      com_err_q  <= '0;
      com_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      wm_a_q     <= wm_a_d;
      wm_b_q     <= wm_b_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      com_a_q    <= com_a_d;
      com_b_q    <= com_b_d;
      com_wm_a_q <= com_wm_a_d;
      com_wm_b_q <= com_wm_b_d;
      com_err_q  <= com_err_d;
      com_mode_q <= com_mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? HOLD : FILL;
      FILL:    if (commit) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q != HOLD);
    out_valid  = (state_q == HOLD);
    out_bank_a = com_a_q;
    out_bank_b = com_b_q;
    out_mode   = com_mode_q;
    out_wmask  = {com_wm_b_q, com_wm_a_q};
    out_err    = com_err_q;
  end

  // Datapath: shadow write, per-frame mask/err accumulation and commit.
  always_comb begin
    accept  = in_valid & in_ready;
    commit  = accept & in_last;
    lane_ok = ({1'b0, in_lane} < LANES_C);
    ovf     = (cnt_q == MAX_C);
`ifdef C8_LOADER_PARITY_EN
    par_ok  = (in_par == ^{in_bank, in_lane, in_data, in_mode, in_last});
`else
    par_ok  = 1'b1;
`endif
    do_write = accept & lane_ok & ~ovf & par_ok;

    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    // Mask and status belong to the current frame only; IDLE means a new frame starts.
    wm_a_d = (state_q == IDLE) ? '0 : wm_a_q;
    wm_b_d = (state_q == IDLE) ? '0 : wm_b_q;
    err_d  = (state_q == IDLE) ? '0 : err_q;
    cnt_d  = cnt_q;

    if (do_write) begin
      if (in_bank) begin
        shadow_b_d[in_lane] = in_data;
        wm_b_d[in_lane]     = 1'b1;
      end else begin
        shadow_a_d[in_lane] = in_data;
        wm_a_d[in_lane]     = 1'b1;
      end
    end
    if (accept) begin
      err_d[0] = err_d[0] | ~lane_ok;
      err_d[1] = err_d[1] | ovf;
`ifdef C8_LOADER_PARITY_EN
      err_d[2] = err_d[2] | ~par_ok;
`endif
      if (!ovf) cnt_d = cnt_q + CNT_W'(1);
    end
    if (commit) cnt_d = '0;

    com_a_d    = com_a_q;
    com_b_d    = com_b_q;
    com_wm_a_d = com_wm_a_q;
    com_wm_b_d = com_wm_b_q;
    com_err_d  = com_err_q;
    com_mode_d = com_mode_q;
    if (commit) begin
      com_a_d    = shadow_a_d;
      com_b_d    = shadow_b_d;
      com_wm_a_d = wm_a_d;
      com_wm_b_d = wm_b_d;
      com_err_d  = err_d;
      com_mode_d = in_mode;
    end
  end

endmodule

// File: tb/tb_c8_bank_loader.sv
// Directed bench for c8_bank_loader: an 8-lane and a 6-lane instance, reference model feeding a frame scoreboard.
module tb_c8_bank_loader;
`ifdef C8_LOADER_PARITY_EN
  localparam int ERR_W = 3;
`else
  localparam int ERR_W = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] iv, ordy, ir, ov, om;
  logic       bank, data, mode, last, par;
  logic [2:0] lane;
  logic [7:0] oa0, ob0;
  logic [5:0] oa1, ob1;
  logic [15:0] owm0;
  logic [11:0] owm1;
  logic [ERR_W-1:0] oerr0, oerr1;

  c8_bank_loader #(.LANES(8), .LANE_W(3), .MAX_BEATS(16)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_bank(bank),
    .in_lane(lane), .in_data(data), .in_mode(mode), .in_last(last),
`ifdef C8_LOADER_PARITY_EN
    .in_par(par),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_bank_a(oa0), .out_bank_b(ob0),
    .out_mode(om[0]), .out_wmask(owm0), .out_err(oerr0));

  c8_bank_loader #(.LANES(6), .LANE_W(3), .MAX_BEATS(16)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_bank(bank),
    .in_lane(lane), .in_data(data), .in_mode(mode), .in_last(last),
`ifdef C8_LOADER_PARITY_EN
    .in_par(par),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_bank_a(oa1), .out_bank_b(ob1),
    .out_mode(om[1]), .out_wmask(owm1), .out_err(oerr1));

  typedef struct {
    int               d;
    logic [7:0]       a, b;
    logic             m;
    logic [15:0]      wm;
    logic [ERR_W-1:0] err;
  } frame_t;

  frame_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [7:0]       ma [2];
  logic [7:0]       mb [2];
  logic [15:0]      mwm [2];
  logic [ERR_W-1:0] me [2];
  int               mcnt [2];
  bit               midle [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      ma[d] = '0; mb[d] = '0; mwm[d] = '0; me[d] = '0; mcnt[d] = 0; midle[d] = 1'b1;
    end
  endfunction

  function automatic void model_beat(int d, logic b, logic [2:0] l, logic v, logic m, logic lst);
    int nl = (d == 0) ? 8 : 6;
    bit ok = 1'b1;
    frame_t f;
    if (midle[d]) begin
      mwm[d] = '0; me[d] = '0; mcnt[d] = 0;
    end
    midle[d] = 1'b0;
    if (int'(l) >= nl) begin me[d][0] = 1'b1; ok = 1'b0; end
    if (mcnt[d] == 16) begin me[d][1] = 1'b1; ok = 1'b0; end
    else mcnt[d]++;
    if (ok) begin
      if (b) begin mb[d][l] = v; mwm[d][nl + int'(l)] = 1'b1; end
      else   begin ma[d][l] = v; mwm[d][l] = 1'b1; end
    end
    if (lst) begin
      f.d = d; f.a = ma[d]; f.b = mb[d]; f.m = m; f.wm = mwm[d]; f.err = me[d];
      sb.push_back(f);
      midle[d] = 1'b1;
      mcnt[d] = 0;
    end
  endfunction

  task automatic send(input int d, input logic b, input logic [2:0] l, input logic v,
                      input logic m, input logic lst);
    int n = 0;
    @(negedge clk);
    bank = b; lane = l; data = v; mode = m; last = lst;
    par = ^{b, l, v, m, lst};
    iv[d] = 1'b1;
    while (!ir[d] && n < 50) begin @(negedge clk); n++; end
    if (!ir[d]) begin
      chk("in_ready_timeout", 32'(ir[d]), 32'd1);
      iv[d] = 1'b0;
    end else begin
      @(posedge clk);
      model_beat(d, b, l, v, m, lst);
      #1 iv[d] = 1'b0;
    end
  endtask

  task automatic check_out(input int d, input string tag);
    frame_t f;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(ov[d]), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      f = sb.pop_front();
      chk({tag, "_bank_a"}, d == 0 ? 32'(oa0) : 32'(oa1), 32'(f.a));
      chk({tag, "_bank_b"}, d == 0 ? 32'(ob0) : 32'(ob1), 32'(f.b));
      chk({tag, "_mode"}, 32'(om[d]), 32'(f.m));
      chk({tag, "_wmask"}, d == 0 ? 32'(owm0) : 32'(owm1), 32'(f.wm));
      chk({tag, "_err"}, d == 0 ? 32'(oerr0) : 32'(oerr1), 32'(f.err));
    end
  endtask

  task automatic release_out(input int d, input string tag);
    ordy[d] = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(ov[d]), 32'd0);
    ordy[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iv = '0; ordy = '0;
    bank = 1'b0; lane = '0; data = 1'b0; mode = 1'b0; last = 1'b0; par = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(ir), 32'h3);
    chk("rst_out_valid", 32'(ov), 32'h0);
    chk("rst_bank_a", 32'(oa0), 32'h0);
    chk("rst_wmask", 32'(owm0), 32'h0);
    chk("rst_err", 32'(oerr0), 32'h0);

    // Three-beat frame on the 8-lane instance.
    send(0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    send(0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1);
    check_out(0, "f1");
    chk("f1_const_a", 32'(oa0), 32'h09);
    chk("f1_const_wm", 32'(owm0), 32'h8009);

    // Consumer stalls while the next beat is already presented.
    bank = 1'b0; lane = 3'd0; data = 1'b0; mode = 1'b0; last = 1'b1;
    par = ^{1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(ir[0]), 32'd0);
      chk("stall_valid", 32'(ov[0]), 32'd1);
      chk("stall_bank_a", 32'(oa0), 32'h09);
      chk("stall_bank_b", 32'(ob0), 32'h80);
    end
    release_out(0, "f1");
    chk("f1_keep_a", 32'(oa0), 32'h09);
    chk("f1_keep_b", 32'(ob0), 32'h80);
    chk("f1_idle_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    model_beat(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    #1 iv[0] = 1'b0;
    check_out(0, "f2");
    chk("f2_const_a", 32'(oa0), 32'h08);
    chk("f2_const_wm", 32'(owm0), 32'h0001);
    release_out(0, "f2");

    // Out-of-range lane on the 6-lane instance, then a clean frame.
    send(1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    send(1, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1);
    check_out(1, "lane");
    chk("lane_const_err", 32'(oerr1), 32'h1);
    release_out(1, "lane");
    send(1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    check_out(1, "clean");
    chk("clean_const_err", 32'(oerr1), 32'h0);
    release_out(1, "clean");

    // 20 beats: the last four are past the limit and dropped.
    for (int i = 1; i <= 20; i++) send(0, 1'b0, 3'd1, 1'b1, 1'b0, i == 20);
    check_out(0, "ovf20");
    chk("ovf20_const_err", 32'(oerr0), 32'h2);
    release_out(0, "ovf20");
    // Exactly MAX_BEATS beats, last beat still written.
    for (int i = 1; i <= 16; i++)
      send(0, 1'b0, i == 16 ? 3'd5 : 3'd1, i == 16, 1'b0, i == 16);
    check_out(0, "max16");
    chk("max16_const_a", 32'(oa0), 32'h28);
    release_out(0, "max16");
    // One beat past the limit: the last beat itself is dropped.
    for (int i = 1; i <= 17; i++)
      send(0, 1'b0, i == 17 ? 3'd6 : 3'd1, 1'b1, 1'b0, i == 17);
    check_out(0, "ovf17");
    chk("ovf17_const_a", 32'(oa0), 32'h2A);
    release_out(0, "ovf17");

    // Reset in the middle of a frame discards everything.
    send(0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    send(0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_ready", 32'(ir[0]), 32'd1);
    chk("mid_rst_a", 32'(oa0), 32'h0);
    chk("mid_rst_b", 32'(ob0), 32'h0);
    chk("mid_rst_mode", 32'(om[0]), 32'h0);
    chk("mid_rst_wm", 32'(owm0), 32'h0);
    chk("mid_rst_err", 32'(oerr0), 32'h0);
    send(0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    check_out(0, "post_rst");
    chk("post_rst_const_b", 32'(ob0), 32'h04);
    release_out(0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
